// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan sequencer.
// Contents: scan FSM state encoding, channel count, default settle time.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } scan_state_e;

    localparam int unsigned NCH           = 4;
    localparam int unsigned DefaultSettle = 2;

endpackage

// File: rtl/mux_scan_timer.sv
// Loadable down-counter used to time the per-channel settle window.
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset (clears the count)
//   load_i      load load_val_i into the counter (has priority over en_i)
//   en_i        decrement by one while the count is non-zero
//   load_val_i  value loaded on load_i
//   zero_o      count is zero
module mux_scan_timer #(
    parameter int unsigned CNTW = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            en_i,
    input  logic [CNTW-1:0] load_val_i,
    output logic            zero_o
);

    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan controller for one section of a 4-to-1 inverting tri-state mux.
// Steps the select lines through channels 0..3, holds each for SETTLE cycles,
// samples the inverted mux output, and presents the re-inverted 4-bit word
// with a one-cycle done pulse. A q that is not 0/1 sets a sticky error flag.
// Optional feature macro: MUX_SCAN_CONTINUOUS_EN (start held in DONE chains
// straight into the next scan with no IDLE cycle).
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   start_i  scan request, honoured only in IDLE (and DONE with the macro)
//   q_i      inverted mux output, may float
//   a1_o     mux select MSB
//   a0_o     mux select LSB
//   oe_o     mux enable, active low
//   busy_o   scan in progress
//   done_o   one-cycle pulse, data_o valid
//   data_o   captured word, data_o[n] = ~q sampled on channel n
//   zerr_o   sticky: some sample of q was not 0/1
module mux_scan_sequencer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE = DefaultSettle,
    parameter int unsigned CNTW   = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       q_i,
    output logic       a1_o,
    output logic       a0_o,
    output logic       oe_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] data_o,
    output logic       zerr_o
);

    localparam logic [CNTW-1:0] LoadVal = CNTW'(SETTLE - 1);

    scan_state_e      state_q, state_d;
    logic [1:0]       ch_q, ch_d;
    logic [NCH-1:0]   shadow_q, shadow_d;
    logic [3:0]       data_q, data_d;
    logic             zerr_q, zerr_d;

    logic tmr_load;
    logic tmr_en;
    logic tmr_zero;
    logic q_unk;

    // A floating or contended line has no logic value to detect in silicon;
    // this only has effect where q can carry x/z.
    assign q_unk = $isunknown(q_i);

    mux_scan_timer #(
        .CNTW (CNTW)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (tmr_load),
        .en_i       (tmr_en),
        .load_val_i (LoadVal),
        .zero_o     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        zerr_d   = zerr_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        oe_o     = 1'b1;
        busy_o   = 1'b0;
        done_o   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d  = StSettle;
                    ch_d     = 2'd0;
                    tmr_load = 1'b1;
                end
            end

            StSettle: begin
                oe_o   = 1'b0;
                busy_o = 1'b1;
                if (tmr_zero) begin
                    state_d = StSample;
                end else begin
                    tmr_en = 1'b1;
                end
            end

            StSample: begin
                oe_o   = 1'b0;
                busy_o = 1'b1;
                shadow_d[ch_q] = q_unk ? 1'bx : ~q_i;
                zerr_d         = zerr_q | q_unk;
                if (ch_q != 2'd3) begin
                    // select advances on the same edge as the sample
                    ch_d     = ch_q + 2'd1;
                    tmr_load = 1'b1;
                    state_d  = StSettle;
                end else begin
                    // publish including the channel-3 sample taken this edge
                    data_d  = shadow_d;
                    state_d = StDone;
                end
            end

            StDone: begin
                done_o  = 1'b1;
                state_d = StIdle;
`ifdef MUX_SCAN_CONTINUOUS_EN
                if (start_i) begin
                    // chain into the next scan; keep the mux enabled
                    oe_o     = 1'b0;
                    busy_o   = 1'b1;
                    state_d  = StSettle;
                    ch_d     = 2'd0;
                    tmr_load = 1'b1;
                end
`endif
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            ch_q     <= 2'd0;
            shadow_q <= '0;
            data_q   <= 4'd0;
            zerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            zerr_q   <= zerr_d;
        end
    end

    assign a1_o   = ch_q[1];
    assign a0_o   = ch_q[0];
    assign data_o = data_q;
    assign zerr_o = zerr_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer. Three instances (SETTLE = 2, 1,
// 15) each drive their own model of an inverting 4-to-1 mux. Expected
// behaviour comes from cycle arithmetic relative to the accepted start edge.
// Honours MUX_SCAN_CONTINUOUS_EN for the back-to-back expectations.
module tb_mux_scan_sequencer;

    localparam int NDut = 3;

`ifdef MUX_SCAN_CONTINUOUS_EN
    localparam bit Cont = 1'b1;
`else
    localparam bit Cont = 1'b0;
`endif

    function automatic int unsigned settle_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] c;      // mux data inputs, channel n carries c[n]
    logic [2:0] fch;    // channel whose input floats (4 = none)
    logic       zval;   // level seen on a floating/disabled mux output

    logic [NDut-1:0]      start_v, q_v, a1_v, a0_v, oe_v, busy_v, done_v, zerr_v;
    logic [NDut-1:0][3:0] data_v;

    int   total = 0;
    int   bad   = 0;
    logic exp_zerr [NDut];

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        logic [1:0] sel;
        assign sel    = {a1_v[g], a0_v[g]};
        assign q_v[g] = (oe_v[g] || ({1'b0, sel} == fch)) ? zval : ~c[sel];

        mux_scan_sequencer #(
            .SETTLE (settle_of(g)),
            .CNTW   (4)
        ) u_dut (
            .clk_i   (clk),
            .rst_i   (rst),
            .start_i (start_v[g]),
            .q_i     (q_v[g]),
            .a1_o    (a1_v[g]),
            .a0_o    (a0_v[g]),
            .oe_o    (oe_v[g]),
            .busy_o  (busy_v[g]),
            .done_o  (done_v[g]),
            .data_o  (data_v[g]),
            .zerr_o  (zerr_v[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] ctl(input int k);
        return {busy_v[k], oe_v[k], done_v[k], a1_v[k], a0_v[k]};
    endfunction

    // One scan on instance k from IDLE; optional stray start pulses mid-scan
    // and in the DONE cycle, both of which must be ignored.
    task automatic run_scan(input int k, input logic [3:0] cv, input logic [2:0] fv,
                            input bit poke_mid, input bit poke_done);
        int unsigned per = settle_of(k) + 1;
        int unsigned lat = 4 * per;
        int unsigned pj;
        logic [3:0]  ed;
        for (int n = 0; n < 4; n++) begin
            if (fv == 3'(n)) ed[n] = $isunknown(zval) ? 1'bx : ~zval;
            else             ed[n] = cv[n];
        end
        if (fv < 3'd4 && $isunknown(zval)) exp_zerr[k] = 1'b1;
        pj = $urandom_range(lat - 1, 1);
        c          = cv;
        fch        = fv;
        start_v[k] = 1'b1;
        @(posedge clk);
        for (int unsigned j = 0; j <= lat; j++) begin
            @(negedge clk);
            if (j < lat) begin
                check($sformatf("scan%0d_ctl_j%0d", k, j), ctl(k),
                      {3'b100, 2'(j / per)});
            end else begin
                check($sformatf("scan%0d_done", k), ctl(k), 5'b01111);
                check($sformatf("scan%0d_data", k), data_v[k], ed);
                check($sformatf("scan%0d_zerr", k), zerr_v[k], exp_zerr[k]);
            end
            start_v[k] = (poke_mid && j == pj) || (poke_done && j == lat);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start_v[k] = 1'b0;
            check($sformatf("scan%0d_idle%0d", k, i), ctl(k) >> 2, 3'b010);
        end
        check($sformatf("scan%0d_hold", k), data_v[k], ed);
        fch = 3'd4;
    endtask

    // start held high across three scans on instance 0, inputs changed after
    // each done.
    task automatic back_to_back();
        int unsigned per    = settle_of(0) + 1;
        int unsigned lat    = 4 * per;
        int unsigned period = lat + (Cont ? 1 : 2);
        logic [3:0]  cs [3];
        int          seen = 0;
        cs[0] = 4'b0011;
        cs[1] = 4'b1100;
        cs[2] = 4'($urandom);
        c          = cs[0];
        fch        = 3'd4;
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int unsigned j = 0; j <= lat + 2 * period; j++) begin
            int unsigned p = j % period;
            logic [2:0]  e;
            @(negedge clk);
            if (p < lat)       e = 3'b100;
            else if (p == lat) e = Cont ? 3'b101 : 3'b011;
            else               e = 3'b010;
            check($sformatf("b2b_ctl_j%0d", j), ctl(0) >> 2, e);
            if (p == lat) begin
                check($sformatf("b2b_data%0d", seen), data_v[0], cs[seen]);
                seen++;
                if (seen < 3) c = cs[seen];
                else          start_v[0] = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_end_idle", ctl(0) >> 2, 3'b010);
        check("b2b_count", seen, 3);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start_v = '0;
        c       = 4'd0;
        fch     = 3'd4;
        zval    = 1'bx;
        for (int k = 0; k < NDut; k++) exp_zerr[k] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NDut; k++) begin
            check($sformatf("rst_ctl%0d", k), ctl(k), 5'b01000);
            check($sformatf("rst_data%0d", k), data_v[k], 4'd0);
            check($sformatf("rst_zerr%0d", k), zerr_v[k], 1'b0);
        end
        rst = 1'b0;

        run_scan(0, 4'b1010, 3'd4, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_scan(0, 4'($urandom), 3'd4, 1'b1, !Cont && ($urandom_range(1, 0) == 1));
        end
        run_scan(0, 4'($urandom), 3'd2, 1'b0, 1'b0);   // channel 2 floats
        run_scan(0, 4'($urandom), 3'd4, 1'b0, 1'b0);   // clean scan, zerr sticky
        run_scan(1, 4'($urandom), 3'd4, 1'b1, 1'b0);
        run_scan(2, 4'($urandom), 3'd4, 1'b0, !Cont);
        back_to_back();

        // reset in the middle of channel 2 on instance 0
        c          = 4'b1111;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2 * (settle_of(0) + 1)) @(negedge clk);
        check("mid_sel_ch2", {a1_v[0], a0_v[0]}, 2'b10);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_ctl", ctl(0), 5'b01000);
        check("midrst_data", data_v[0], 4'd0);
        check("midrst_zerr", zerr_v[0], 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NDut; k++) exp_zerr[k] = 1'b0;
        check("postrst_ctl", ctl(0), 5'b01000);
        run_scan(0, 4'($urandom), 3'd4, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
